// File: rtl/core_pkg.sv
// core_pkg: shared MEM-stage types and transfer-size constants.
package core_pkg;
    typedef enum logic [1:0] {IDLE, REQ, RESP} mem_state_t;
    localparam logic [2:0] XFER_B = 3'd1;
    localparam logic [2:0] XFER_H = 3'd2;
    localparam logic [2:0] XFER_W = 3'd4;
endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: word-wide request/acknowledge data-memory bus.
interface mem_access_ctrl_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    modport master(output req, we, addr, be, wdata, input ack, rdata);
    modport slave(input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_ctrl_load_align.sv
// load_align: lane select and sign/zero extension of a bus read word.
module load_align
    import core_pkg::*;
(
    input  logic [31:0] bus_rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] load_data
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    always_comb begin
        lane_b = bus_rdata[{offset, 3'b000} +: 8];
        lane_h = bus_rdata[{offset[1], 4'b0000} +: 16];
        load_data = size == XFER_B ? {{24{~is_unsigned & lane_b[7]}}, lane_b} :
                    size == XFER_H ? {{16{~is_unsigned & lane_h[15]}}, lane_h} : bus_rdata;
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences MEM-stage loads/stores onto a req/ack word bus,
// stalling the pipeline while an access is outstanding.
module mem_access_ctrl
    import core_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        flush,
    input  logic [2:0]  xfer_size,
    input  logic        is_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        done,
    output logic        misaligned,
    output logic        bus_err,
    mem_access_ctrl_if.master bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    mem_state_t state_q, state_d;
    logic req_q, req_d, we_q, we_d, uns_q, uns_d, done_q, done_d, mis_q, mis_d, err_q, err_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, load_data_q, load_data_d, aligned;
    logic [3:0] be_q, be_d;
    logic [1:0] off_q, off_d;
    logic [2:0] size_q, size_d, size;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic op, bad;
    load_align u_align (.bus_rdata(bus.rdata), .offset(off_q), .size(size_q),
                        .is_unsigned(uns_q), .load_data(aligned));
    always_comb begin
        op = (mem_read | mem_write) & ~flush;
        size = xfer_size == XFER_B ? XFER_B : xfer_size == XFER_H ? XFER_H : XFER_W;
        bad = size == XFER_H ? addr[0] : size == XFER_W ? |addr[1:0] : 1'b0;
        stall = (state_q == IDLE && op && !bad) || state_q == REQ;
        state_d = state_q;
        req_d = req_q;
        we_d = we_q;
        addr_d = addr_q;
        be_d = be_q;
        wdata_d = wdata_q;
        off_d = off_q;
        size_d = size_q;
        uns_d = uns_q;
        load_data_d = load_data_q;
        cnt_d = cnt_q;
        done_d = 1'b0;
        mis_d = 1'b0;
        err_d = 1'b0;
        if (state_q == IDLE && op && bad) begin
            mis_d = 1'b1;
        end else if (state_q == IDLE && op) begin
            state_d = REQ;
            req_d = 1'b1;
            we_d = mem_write;
            addr_d = {addr[31:2], 2'b00};
            be_d = size == XFER_B ? 4'b0001 << addr[1:0] : size == XFER_H ? 4'b0011 << addr[1:0] : 4'b1111;
            wdata_d = size == XFER_B ? {4{wdata[7:0]}} : size == XFER_H ? {2{wdata[15:0]}} : wdata;
            off_d = addr[1:0];
            size_d = size;
            uns_d = is_unsigned;
            cnt_d = '0;
        end else if (state_q == REQ && bus.ack) begin
            state_d = RESP;
            req_d = 1'b0;
            done_d = 1'b1;
            load_data_d = we_q ? load_data_q : aligned;
        end else if (state_q == REQ) begin
            // Ack wins over timeout; bus_req stays up for at most TIMEOUT cycles.
            cnt_d = CNT_W'(cnt_q + 1'b1);
            if (cnt_d == CNT_W'(TIMEOUT)) begin
                state_d = RESP;
                req_d = 1'b0;
                done_d = 1'b1;
                err_d = 1'b1;
            end
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q <= 1'b0;
            we_q <= 1'b0;
            addr_q <= '0;
            be_q <= '0;
            wdata_q <= '0;
            off_q <= '0;
            size_q <= '0;
            uns_q <= 1'b0;
            load_data_q <= '0;
            cnt_q <= '0;
            done_q <= 1'b0;
            mis_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q <= req_d;
            we_q <= we_d;
            addr_q <= addr_d;
            be_q <= be_d;
            wdata_q <= wdata_d;
            off_q <= off_d;
            size_q <= size_d;
            uns_q <= uns_d;
            load_data_q <= load_data_d;
            cnt_q <= cnt_d;
            done_q <= done_d;
            mis_q <= mis_d;
            err_q <= err_d;
        end
    end
    assign bus.req = req_q;
    assign bus.we = we_q;
    assign bus.addr = addr_q;
    assign bus.be = be_q;
    assign bus.wdata = wdata_q;
    assign load_data = load_data_q;
    assign done = done_q;
    assign misaligned = mis_q;
    assign bus_err = err_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and randomized checks of mem_access_ctrl against a byte-arithmetic model.
module tb_mem_access_ctrl;
    localparam int TO = 4;
    logic clk = 1'b0;
    logic reset, mem_read, mem_write, flush, is_unsigned, stall, done, misaligned, bus_err;
    logic [2:0] xfer_size;
    logic [31:0] addr, wdata, load_data;
    int errors = 0;
    int checks = 0;
    logic [31:0] last_ld;
    typedef struct {
        int stall_n; int done_cyc; int req_n;
        logic stall1; logic err; logic mis; logic mis_after; logic we; logic stable;
        logic [3:0] be; logic [31:0] baddr; logic [31:0] bwd; logic [31:0] ld;
    } obs_t;

    mem_access_ctrl_if bus();
    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write), .flush(flush),
        .xfer_size(xfer_size), .is_unsigned(is_unsigned), .addr(addr), .wdata(wdata),
        .stall(stall), .load_data(load_data), .done(done), .misaligned(misaligned),
        .bus_err(bus_err), .bus(bus)
    );
    always #5 clk = ~clk;

    function automatic int norm(input logic [2:0] sz);
        return (sz == 3'd1 || sz == 3'd2) ? int'(sz) : 4;
    endfunction
    function automatic logic [3:0] m_be(input int n, input logic [31:0] a);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction
    function automatic logic [31:0] m_wdata(input int n, input logic [31:0] wd);
        logic [31:0] r = 0;
        for (int i = 0; i < 4; i++) r |= ((wd >> (8 * (i % n))) & 32'hFF) << (8 * i);
        return r;
    endfunction
    function automatic logic [31:0] m_load(input int n, input logic un, input logic [31:0] a, input logic [31:0] rd);
        longint v = 64'(rd >> (8 * (a % 4)));
        if (n < 4) begin
            v = v & ((64'd1 << (8 * n)) - 1);
            if (!un && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
        end
        return v[31:0];
    endfunction

    task automatic idle();
        mem_read = 0; mem_write = 0; flush = 0;
    endtask

    // Presents one op, plays the bus slave (ack on REQ cycle ack_at, 0 = never) and records what happened.
    task automatic run_op(input logic rd, input logic wr, input logic fl, input logic [2:0] sz,
                          input logic un, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdat, input int ack_at, output obs_t o);
        o = '{default: 0};
        o.done_cyc = -1;
        o.stable = 1;
        @(negedge clk);
        mem_read = rd; mem_write = wr; flush = fl; xfer_size = sz; is_unsigned = un; addr = a; wdata = wd;
        bus.ack = 0;
        #1;
        o.stall1 = stall;
        if (!stall) begin
            @(negedge clk);
            idle();
            #1;
            o.mis = misaligned; o.req_n += int'(bus.req);
            @(negedge clk);
            #1;
            o.mis_after = misaligned; o.req_n += int'(bus.req);
            return;
        end
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) begin @(negedge clk); #1; end
            o.stall_n += int'(stall);
            if (bus.req) begin
                if (o.req_n == 0) begin
                    o.be = bus.be; o.baddr = bus.addr; o.bwd = bus.wdata; o.we = bus.we;
                end else if (bus.be !== o.be || bus.addr !== o.baddr || bus.wdata !== o.bwd || bus.we !== o.we) begin
                    o.stable = 0;
                end
                o.req_n++;
                bus.ack = (o.req_n == ack_at);
                bus.rdata = bus.ack ? rdat : $urandom;
            end else begin
                bus.ack = 0;
            end
            if (done) begin
                o.done_cyc = c; o.err = bus_err; o.ld = load_data;
                idle();
                return;
            end
        end
        idle();
    endtask

    task automatic test_reset();
        reset = 1; idle(); xfer_size = 4; is_unsigned = 0; addr = 0; wdata = 0;
        bus.ack = 0; bus.rdata = 0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bus.req, bus.we, bus.be, bus.addr, bus.wdata, load_data, done, misaligned, bus_err, stall} !== '0) begin
            errors++; $display("FAIL reset_outputs got req=%b be=%b addr=%h ld=%h done=%b exp all zero", bus.req, bus.be, bus.addr, load_data, done);
        end
        reset = 0;
        last_ld = 0;
    endtask

    task automatic test_store_word();
        obs_t o;
        run_op(0, 1, 0, 3'd4, 0, 32'h1004, 32'hDEADBEEF, 0, 1, o);
        checks++; if (o.be !== 4'b1111) begin errors++; $display("FAIL sw_be got=%b exp=1111", o.be); end
        checks++; if (o.baddr !== 32'h1004) begin errors++; $display("FAIL sw_addr got=%h exp=00001004", o.baddr); end
        checks++; if (o.bwd !== 32'hDEADBEEF || o.we !== 1'b1) begin errors++; $display("FAIL sw_wdata got=%h we=%b exp=deadbeef we=1", o.bwd, o.we); end
        checks++; if (o.stall_n != 2 || o.done_cyc != 3) begin errors++; $display("FAIL sw_latency got stall=%0d done=%0d exp 2/3", o.stall_n, o.done_cyc); end
        checks++; if (o.err !== 1'b0) begin errors++; $display("FAIL sw_err got=%b exp=0", o.err); end
    endtask

    task automatic test_load_byte();
        obs_t o;
        run_op(1, 0, 0, 3'd1, 0, 32'h2003, 0, 32'h80FF_1234, 1, o);
        checks++; if (o.be !== 4'b1000 || o.baddr !== 32'h2000 || o.we !== 1'b0) begin errors++; $display("FAIL lb_bus got be=%b addr=%h we=%b exp be=1000 addr=00002000 we=0", o.be, o.baddr, o.we); end
        checks++; if (o.ld !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data got=%h exp=ffffff80", o.ld); end
        run_op(1, 0, 0, 3'd1, 1, 32'h2003, 0, 32'h80FF_1234, 2, o);
        checks++; if (o.ld !== 32'h00000080) begin errors++; $display("FAIL lbu_data got=%h exp=00000080", o.ld); end
        checks++; if (o.stall_n != 3 || o.done_cyc != 4) begin errors++; $display("FAIL lbu_latency got stall=%0d done=%0d exp 3/4", o.stall_n, o.done_cyc); end
        last_ld = 32'h80;
    endtask

    task automatic test_store_half();
        obs_t o;
        run_op(0, 1, 0, 3'd2, 0, 32'h0002, 32'h0000ABCD, 0, 1, o);
        checks++; if (o.be !== 4'b1100) begin errors++; $display("FAIL sh_be got=%b exp=1100", o.be); end
        checks++; if (o.bwd !== 32'hABCDABCD) begin errors++; $display("FAIL sh_wdata got=%h exp=abcdabcd", o.bwd); end
        checks++; if (o.ld !== last_ld) begin errors++; $display("FAIL sh_ld_hold got=%h exp=%h", o.ld, last_ld); end
    endtask

    task automatic test_misaligned();
        obs_t o;
        run_op(1, 0, 0, 3'd4, 0, 32'h0001, 0, 0, 1, o);
        checks++; if (o.stall1 !== 0 || o.mis !== 1 || o.mis_after !== 0 || o.req_n != 0) begin errors++; $display("FAIL lw_mis got stall=%b mis=%b after=%b req=%0d exp 0/1/0/0", o.stall1, o.mis, o.mis_after, o.req_n); end
        run_op(1, 0, 0, 3'd2, 1, 32'h0003, 0, 0, 1, o);
        checks++; if (o.stall1 !== 0 || o.mis !== 1 || o.mis_after !== 0 || o.req_n != 0) begin errors++; $display("FAIL lh_mis got stall=%b mis=%b after=%b req=%0d exp 0/1/0/0", o.stall1, o.mis, o.mis_after, o.req_n); end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_op(1, 0, 0, 3'd4, 0, 32'h40, 0, 32'h12345678, 0, o);
        checks++; if (o.req_n != TO || o.done_cyc != TO + 2 || o.err !== 1) begin errors++; $display("FAIL timeout got req=%0d done=%0d err=%b exp %0d/%0d/1", o.req_n, o.done_cyc, o.err, TO, TO + 2); end
        checks++; if (o.ld !== last_ld || o.stable !== 1) begin errors++; $display("FAIL timeout_hold got ld=%h stable=%b exp ld=%h stable=1", o.ld, o.stable, last_ld); end
        run_op(0, 1, 0, 3'd4, 0, 32'h44, 32'h1, 0, TO, o);
        checks++; if (o.req_n != TO || o.done_cyc != TO + 2 || o.err !== 0) begin errors++; $display("FAIL last_ack got req=%0d done=%0d err=%b exp %0d/%0d/0", o.req_n, o.done_cyc, o.err, TO, TO + 2); end
    endtask

    task automatic test_flush();
        obs_t o;
        int seen = 0;
        run_op(1, 0, 1, 3'd4, 0, 32'h80, 0, 0, 1, o);
        checks++; if (o.stall1 !== 0 || o.mis !== 0 || o.req_n != 0) begin errors++; $display("FAIL flush got stall=%b mis=%b req=%0d exp 0/0/0", o.stall1, o.mis, o.req_n); end
        bus.ack = 1;
        repeat (3) begin @(negedge clk); #1; seen += int'(done) + int'(bus.req) + int'(stall); end
        bus.ack = 0;
        checks++; if (seen != 0) begin errors++; $display("FAIL idle_ack got activity=%0d exp=0", seen); end
    endtask

    task automatic test_reset_req();
        obs_t o;
        int seen = 0;
        @(negedge clk);
        mem_read = 1; xfer_size = 3'd4; addr = 32'h100; is_unsigned = 0;
        @(negedge clk);
        idle();
        #1;
        checks++; if (bus.req !== 1) begin errors++; $display("FAIL rst_req_pre got req=%b exp=1", bus.req); end
        reset = 1;
        @(negedge clk);
        #1;
        reset = 0;
        checks++; if (bus.req !== 0 || done !== 0) begin errors++; $display("FAIL rst_req_drop got req=%b done=%b exp 0/0", bus.req, done); end
        repeat (3) begin @(negedge clk); #1; seen += int'(done) + int'(bus.req); end
        checks++; if (seen != 0) begin errors++; $display("FAIL rst_req_quiet got activity=%0d exp=0", seen); end
        last_ld = 0;
        run_op(0, 1, 0, 3'd1, 0, 32'h101, 32'h55, 0, 1, o);
        checks++; if (o.stall_n != 2 || o.done_cyc != 3 || o.be !== 4'b0010) begin errors++; $display("FAIL rst_req_idle got stall=%0d done=%0d be=%b exp 2/3/0010", o.stall_n, o.done_cyc, o.be); end
    endtask

    task automatic test_random();
        obs_t o;
        logic [2:0] sizes [6] = '{3'd1, 3'd2, 3'd4, 3'd0, 3'd3, 3'd7};
        for (int t = 0; t < 60; t++) begin
            int k = $urandom_range(0, 2);
            logic [2:0] sz = sizes[$urandom_range(0, 5)];
            int n = norm(sz);
            logic un = 1'($urandom);
            logic [31:0] a = $urandom;
            logic [31:0] wd = $urandom;
            logic [31:0] rdat = $urandom;
            int ack_at = $urandom_range(0, TO + 1);
            bit is_ld = (k == 0);
            int n_ack;
            bit exp_err;
            if ($urandom_range(0, 4) != 0) a = a & ~32'(n - 1);
            run_op(k != 1, k != 0, 0, sz, un, a, wd, rdat, ack_at, o);
            if (a % n != 0) begin
                checks++; if (o.stall1 !== 0 || o.mis !== 1 || o.req_n != 0) begin errors++; $display("FAIL rnd_mis t=%0d got stall=%b mis=%b req=%0d exp 0/1/0", t, o.stall1, o.mis, o.req_n); end
                continue;
            end
            exp_err = !(ack_at >= 1 && ack_at <= TO);
            n_ack = exp_err ? TO : ack_at;
            if (is_ld && !exp_err) last_ld = m_load(n, un, a, rdat);
            checks++;
            if (o.stall_n != n_ack + 1 || o.done_cyc != n_ack + 2 || o.err !== exp_err || o.stable !== 1) begin
                errors++; $display("FAIL rnd_timing t=%0d got stall=%0d done=%0d err=%b stable=%b exp %0d/%0d/%b/1", t, o.stall_n, o.done_cyc, o.err, o.stable, n_ack + 1, n_ack + 2, exp_err);
            end
            checks++;
            if (o.be !== m_be(n, a) || o.baddr !== {a[31:2], 2'b00} || o.we !== !is_ld || (!is_ld && o.bwd !== m_wdata(n, wd))) begin
                errors++; $display("FAIL rnd_bus t=%0d got be=%b addr=%h we=%b wd=%h exp be=%b addr=%h we=%b wd=%h", t, o.be, o.baddr, o.we, o.bwd, m_be(n, a), {a[31:2], 2'b00}, !is_ld, m_wdata(n, wd));
            end
            checks++;
            if (o.ld !== last_ld) begin errors++; $display("FAIL rnd_load t=%0d got=%h exp=%h", t, o.ld, last_ld); end
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_timeout();
        test_flush();
        test_reset_req();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequences data-memory loads and stores from the MEM stage of the pipelined RV32I core onto a word-wide request/acknowledge memory bus. It is driven by the decoder's mem_read, mem_write, xfer_size and is_unsigned flags. It computes byte lanes, replicates store data, and extracts and extends load data. It stalls the pipeline while an access is outstanding, and reports misalignment and bus timeout.

Parameters:
TIMEOUT, 255, maximum cycles bus_req may wait for bus_ack before aborting with bus_err
CNT_W, $clog2(TIMEOUT+1), width of the wait counter; derived, never overridden

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
mem_read  in  1  MEM-stage instruction is a load
mem_write  in  1  MEM-stage instruction is a store
flush  in  1  kill the MEM-stage op before it reaches the bus
xfer_size  in  3  transfer size in bytes: 1, 2 or 4
is_unsigned  in  1  zero-extend load result
addr  in  32  effective byte address from the ALU
wdata  in  32  store data, right-aligned
stall  out  1  hold all pipeline registers upstream of MEM/WB
load_data  out  32  extended load result; valid when done=1
done  out  1  one-cycle pulse: access finished, pipeline advances
misaligned  out  1  one-cycle pulse: access rejected for alignment
bus_err  out  1  one-cycle pulse, coincident with done: access timed out
bus_req  out  1  bus request, held until bus_ack
bus_we  out  1  1 = write
bus_addr  out  32  word address, {addr[31:2],2'b00}
bus_be  out  4  byte enables
bus_wdata  out  32  lane-replicated store data
bus_ack  in  1  bus completes the access this cycle
bus_rdata  in  32  read data, valid with bus_ack

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. On reset, state goes to IDLE and all registered outputs clear: bus_req, bus_we, bus_addr, bus_be, bus_wdata, load_data, done, misaligned, bus_err and the counter.
- Reset mid-access: bus_req deasserts the cycle after reset is sampled. No done pulse is produced.
- FSM states: IDLE, REQ, RESP.
- Op decode: op = (mem_read | mem_write) & ~flush. If both read and write are set, the op is a store.
- Unsupported xfer_size values are treated as 4.
- Alignment: a halfword with addr[0]=1 is misaligned; a word with addr[1:0]!=0 is misaligned.
- IDLE, misaligned op: pulse misaligned next cycle, issue no bus access, stay in IDLE.
  - stall is 0 throughout, so the pipeline advances; trap handling is external.
- IDLE, aligned op: register bus_addr, bus_we, bus_be, bus_wdata, lane and sign info; set bus_req=1; go to REQ.
  - stall is combinationally 1 in this cycle.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<addr[1:0]
  - word: 4'b1111
- Store data replication:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- REQ: stall=1, and bus address, we, be and wdata are held stable.
  - On bus_ack: drop bus_req; capture the load result (loads only); go to RESP.
  - Counter reaches TIMEOUT with no ack: drop bus_req, set bus_err, go to RESP.
  - flush is ignored in REQ; an issued access cannot be aborted.
- Load extraction: select the lane by the registered addr[1:0]. Sign-extend from bit 7 or bit 15 unless is_unsigned. Words pass through unchanged.
  - load_data holds its value until the next load completes.
- RESP: done=1 and stall=0, so the pipeline advances at the end of this cycle; go to IDLE.
  - A new op is accepted in IDLE the following cycle.
- Minimum latency: an access completing on the first bus_ack stalls 2 cycles (IDLE, REQ) and pulses done in the 3rd.
- bus_ack sampled outside REQ is ignored.
- Counter: clears on entering REQ and increments each REQ cycle without ack.

Decomposition:
- Shared package core_pkg holds:
  - state enum mem_state_t {IDLE, REQ, RESP}
  - size constants XFER_B=1, XFER_H=2, XFER_W=4
- Sub-module load_align (combinational): lane select plus sign/zero extend.
  - Inputs: bus_rdata, offset, size, is_unsigned.
  - Output: load_data.
  - Reused later for store-to-load forwarding.

Test Plan:
- Store word: addr=0x1004, wdata=0xDEADBEEF, ack on the 1st REQ cycle -> bus_be=1111, bus_addr=0x1004, stall high 2 cycles, done in cycle 3.
- Byte load, sign-extended: lb at addr=0x2003, bus_rdata=0x80FF_1234 -> bus_be=1000, load_data=0xFFFFFF80.
- Byte load, zero-extended: lbu at the same address and data -> load_data=0x00000080.
- Halfword store: sh at addr=0x0002, wdata=0x0000ABCD -> bus_be=1100, bus_wdata=0xABCDABCD.
- Misalignment: lw at addr=0x0001 -> misaligned pulses, bus_req never rises, stall=0.
- Misalignment: lh at addr=0x0003 -> same response as above.
- Timeout and flush: with TIMEOUT=4 and no ack -> bus_req drops after 4 REQ cycles, bus_err and done pulse together.
- Flush in IDLE: flush with mem_read -> no request issued.
- Reset in REQ: reset asserted during REQ -> bus_req=0 the next cycle, no done, state IDLE.
